// File: rtl/cpu_pkg.sv
// Shared CPU constants: ALU op / funct encodings and mult/div FSM state type.
package cpu_pkg;

  localparam int unsigned REG_W = 5;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_OR    = 2'b11;

  localparam logic [5:0] FUNCT_SLL   = 6'h00;
  localparam logic [5:0] FUNCT_SRL   = 6'h02;
  localparam logic [5:0] FUNCT_MFHI  = 6'h10;
  localparam logic [5:0] FUNCT_MFLO  = 6'h12;
  localparam logic [5:0] FUNCT_MULTU = 6'h19;
  localparam logic [5:0] FUNCT_DIVU  = 6'h1B;
  localparam logic [5:0] FUNCT_ADD   = 6'h20;
  localparam logic [5:0] FUNCT_ADDU  = 6'h21;
  localparam logic [5:0] FUNCT_SUB   = 6'h22;
  localparam logic [5:0] FUNCT_SUBU  = 6'h23;
  localparam logic [5:0] FUNCT_AND   = 6'h24;
  localparam logic [5:0] FUNCT_OR    = 6'h25;
  localparam logic [5:0] FUNCT_SLT   = 6'h2A;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_MUL  = 2'd1,
    MD_DIV  = 2'd2
  } md_state_e;

  // True for R-type functs that read or write HI/LO and must wait for the unit.
  function automatic logic is_md_funct(input logic [5:0] f);
    return (f == FUNCT_MFHI) || (f == FUNCT_MFLO) ||
           (f == FUNCT_MULTU) || (f == FUNCT_DIVU);
  endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative unsigned multiply (shift-add) / divide (restoring) unit owning HI and LO.
module muldiv_unit
  import cpu_pkg::*;
#(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] HILO_RST = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_start_mul,
  input  logic            i_start_div,
  input  logic [XLEN-1:0] i_op_a,
  input  logic [XLEN-1:0] i_op_b,
  output logic            o_busy,
  output logic [XLEN-1:0] o_hi,
  output logic [XLEN-1:0] o_lo
);

  localparam int unsigned CNT_W = (XLEN > 1) ? $clog2(XLEN) : 1;

  md_state_e         r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [XLEN-1:0]   r_acc;
  logic [XLEN-1:0]   r_q;
  logic [XLEN-1:0]   r_b;
  logic [XLEN-1:0]   r_hi;
  logic [XLEN-1:0]   r_lo;
  logic              r_busy;

  logic [XLEN:0]     w_mul_sum;
  logic [XLEN-1:0]   w_mul_acc;
  logic [XLEN-1:0]   w_mul_q;
  logic [XLEN:0]     w_div_shift;
  logic [XLEN:0]     w_div_diff;
  logic              w_div_ok;
  logic [XLEN-1:0]   w_div_acc;
  logic [XLEN-1:0]   w_div_q;

  // Multiply step: r_acc:r_q is the running product, multiplier bits retire from r_q[0].
  always_comb begin
    w_mul_sum = {1'b0, r_acc} + (r_q[0] ? {1'b0, r_b} : (XLEN+1)'(0));
    w_mul_acc = w_mul_sum[XLEN:1];
    w_mul_q   = {w_mul_sum[0], r_q[XLEN-1:1]};
  end

  // Divide step: r_acc is the partial remainder, dividend bits shift out of r_q as quotient bits shift in.
  always_comb begin
    w_div_shift = {r_acc, r_q[XLEN-1]};
    w_div_diff  = w_div_shift - {1'b0, r_b};
    w_div_ok    = ~w_div_diff[XLEN];
    w_div_acc   = w_div_ok ? w_div_diff[XLEN-1:0] : w_div_shift[XLEN-1:0];
    w_div_q     = {r_q[XLEN-2:0], w_div_ok};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= MD_IDLE;
      r_cnt   <= '0;
      r_acc   <= '0;
      r_q     <= '0;
      r_b     <= '0;
      r_hi    <= HILO_RST;
      r_lo    <= HILO_RST;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        MD_IDLE: begin
          if (i_start_mul || i_start_div) begin
            r_state <= i_start_mul ? MD_MUL : MD_DIV;
            r_cnt   <= CNT_W'(XLEN - 1);
            r_acc   <= '0;
            r_q     <= i_op_a;
            r_b     <= i_op_b;
            r_busy  <= 1'b1;
          end
        end
        MD_MUL: begin
          r_acc <= w_mul_acc;
          r_q   <= w_mul_q;
          if (r_cnt == '0) begin
            r_hi    <= w_mul_acc;
            r_lo    <= w_mul_q;
            r_state <= MD_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        MD_DIV: begin
          r_acc <= w_div_acc;
          r_q   <= w_div_q;
          if (r_cnt == '0) begin
            r_hi    <= w_div_acc;
            r_lo    <= w_div_q;
            r_state <= MD_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        default: begin
          r_state <= MD_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_busy = r_busy;
  assign o_hi   = r_hi;
  assign o_lo   = r_lo;

endmodule

// File: rtl/ex_stage.sv
// Execute stage: ALU, destination select, zero flag, EX/MEM control gating and mult/div stall generation.
module ex_stage
  import cpu_pkg::*;
#(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] HILO_RST = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ext_hold,
  input  logic             RegDst,
  input  logic             ALUSrc,
  input  logic             RegWrite,
  input  logic             MemRead,
  input  logic             MemWrite,
  input  logic             MemtoReg,
  input  logic             R31toReg,
  input  logic [1:0]       ALUop,
  input  logic [XLEN-1:0]  RD1,
  input  logic [XLEN-1:0]  RD2,
  input  logic [XLEN-1:0]  extend_immed,
  input  logic [REG_W-1:0] rt,
  input  logic [REG_W-1:0] rd,
  input  logic [4:0]       shamt,
  input  logic [5:0]       funct,
  output logic [XLEN-1:0]  alu_result,
  output logic [XLEN-1:0]  store_data,
  output logic [REG_W-1:0] wr_reg,
  output logic             zero,
  output logic             ex_RegWrite,
  output logic             ex_MemRead,
  output logic             ex_MemWrite,
  output logic             ex_MemtoReg,
  output logic             md_stall,
  output logic             md_busy
);

  logic [XLEN-1:0] w_op_b;
  logic [XLEN-1:0] w_alu;
  logic [XLEN-1:0] w_hi;
  logic [XLEN-1:0] w_lo;
  logic            w_busy;
  logic            w_rtype;
  logic            w_stall;
  logic            w_start_mul;
  logic            w_start_div;

  assign w_op_b  = ALUSrc ? extend_immed : RD2;
  assign w_rtype = (ALUop == ALUOP_RTYPE);

  // Issue only from an idle unit; a held ID/EX must not launch the same op twice.
  assign w_stall     = w_busy & w_rtype & is_md_funct(funct);
  assign w_start_mul = ~w_busy & w_rtype & ~ext_hold & (funct == FUNCT_MULTU);
  assign w_start_div = ~w_busy & w_rtype & ~ext_hold & (funct == FUNCT_DIVU);

  always_comb begin
    w_alu = '0;
    case (ALUop)
      ALUOP_ADD: w_alu = RD1 + w_op_b;
      ALUOP_SUB: w_alu = RD1 - w_op_b;
      ALUOP_OR:  w_alu = RD1 | w_op_b;
      default: begin
        case (funct)
          FUNCT_ADD, FUNCT_ADDU: w_alu = RD1 + w_op_b;
          FUNCT_SUB, FUNCT_SUBU: w_alu = RD1 - w_op_b;
          FUNCT_AND:             w_alu = RD1 & w_op_b;
          FUNCT_OR:              w_alu = RD1 | w_op_b;
          FUNCT_SLT:             w_alu[0] = ($signed(RD1) < $signed(w_op_b));
          FUNCT_SLL:             w_alu = w_op_b << shamt;
          FUNCT_SRL:             w_alu = w_op_b >> shamt;
          FUNCT_MFHI:            w_alu = w_hi;
          FUNCT_MFLO:            w_alu = w_lo;
          default:               w_alu = '0;
        endcase
      end
    endcase
  end

  muldiv_unit #(
    .XLEN     (XLEN),
    .HILO_RST (HILO_RST)
  ) u_muldiv (
    .clk         (clk),
    .rst         (rst),
    .i_start_mul (w_start_mul),
    .i_start_div (w_start_div),
    .i_op_a      (RD1),
    .i_op_b      (RD2),
    .o_busy      (w_busy),
    .o_hi        (w_hi),
    .o_lo        (w_lo)
  );

  assign alu_result  = w_alu;
  assign zero        = (w_alu == '0);
  assign store_data  = RD2;
  assign wr_reg      = R31toReg ? REG_W'(31) : (RegDst ? rd : rt);
  assign ex_RegWrite = RegWrite & ~w_stall;
  assign ex_MemRead  = MemRead  & ~w_stall;
  assign ex_MemWrite = MemWrite & ~w_stall;
  assign ex_MemtoReg = MemtoReg & ~w_stall;
  assign md_stall    = w_stall;
  assign md_busy     = w_busy;

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: directed corner cases then randomized instructions vs. a cycle-level model.
module tb_ex_stage;

  localparam int unsigned XLEN = 32;

  logic        clk = 1'b0;
  logic        rst, ext_hold, RegDst, ALUSrc, RegWrite, MemRead, MemWrite, MemtoReg, R31toReg;
  logic [1:0]  ALUop;
  logic [31:0] RD1, RD2, extend_immed;
  logic [4:0]  rt, rd, shamt;
  logic [5:0]  funct;
  logic [31:0] alu_result, store_data;
  logic [4:0]  wr_reg;
  logic        zero, ex_RegWrite, ex_MemRead, ex_MemWrite, ex_MemtoReg, md_stall, md_busy;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  // Reference model: cycles of busy remaining plus architectural and pending HI/LO.
  int          md_left = 0;
  logic [31:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;

  always #5 clk = ~clk;

  ex_stage #(.XLEN(XLEN), .HILO_RST(32'h0)) dut (
    .clk(clk), .rst(rst), .ext_hold(ext_hold), .RegDst(RegDst), .ALUSrc(ALUSrc),
    .RegWrite(RegWrite), .MemRead(MemRead), .MemWrite(MemWrite), .MemtoReg(MemtoReg),
    .R31toReg(R31toReg), .ALUop(ALUop), .RD1(RD1), .RD2(RD2), .extend_immed(extend_immed),
    .rt(rt), .rd(rd), .shamt(shamt), .funct(funct), .alu_result(alu_result),
    .store_data(store_data), .wr_reg(wr_reg), .zero(zero), .ex_RegWrite(ex_RegWrite),
    .ex_MemRead(ex_MemRead), .ex_MemWrite(ex_MemWrite), .ex_MemtoReg(ex_MemtoReg),
    .md_stall(md_stall), .md_busy(md_busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_alu(input logic [1:0] op, input logic [5:0] fn,
                                          input logic [31:0] a, input logic [31:0] b,
                                          input logic [4:0] sh);
    case (op)
      2'b00: return a + b;
      2'b01: return a - b;
      2'b11: return a | b;
      default: begin
        case (fn)
          6'h20, 6'h21: return a + b;
          6'h22, 6'h23: return a - b;
          6'h24: return a & b;
          6'h25: return a | b;
          6'h2A: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
          6'h00: return b << sh;
          6'h02: return b >> sh;
          6'h10: return m_hi;
          6'h12: return m_lo;
          default: return 32'd0;
        endcase
      end
    endcase
  endfunction

  task automatic nop();
    rst = 0; ext_hold = 0; RegDst = 0; ALUSrc = 0; RegWrite = 0; MemRead = 0;
    MemWrite = 0; MemtoReg = 0; R31toReg = 0; ALUop = 2'b00; RD1 = 0; RD2 = 0;
    extend_immed = 0; rt = 0; rd = 0; shamt = 0; funct = 0;
  endtask

  task automatic rtype(input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b);
    ALUop = 2'b10; funct = fn; RD1 = a; RD2 = b; ALUSrc = 0;
  endtask

  // One clock: check every output mid-cycle against the model, then advance the model at the edge.
  task automatic cycle();
    logic        busy, stall, md_fn;
    logic [31:0] opb, exp_alu;
    logic [63:0] prod;
    @(negedge clk);
    busy    = (md_left > 0);
    md_fn   = (funct == 6'h10) || (funct == 6'h12) || (funct == 6'h19) || (funct == 6'h1B);
    stall   = busy && (ALUop == 2'b10) && md_fn;
    opb     = ALUSrc ? extend_immed : RD2;
    exp_alu = ref_alu(ALUop, funct, RD1, opb, shamt);
    chk("md_busy", 32'(md_busy), 32'(busy));
    chk("md_stall", 32'(md_stall), 32'(stall));
    chk("ex_RegWrite", 32'(ex_RegWrite), 32'(RegWrite && !stall));
    chk("ex_MemRead", 32'(ex_MemRead), 32'(MemRead && !stall));
    chk("ex_MemWrite", 32'(ex_MemWrite), 32'(MemWrite && !stall));
    chk("ex_MemtoReg", 32'(ex_MemtoReg), 32'(MemtoReg && !stall));
    chk("wr_reg", 32'(wr_reg), 32'(R31toReg ? 5'd31 : (RegDst ? rd : rt)));
    chk("store_data", store_data, RD2);
    if (!stall) begin
      chk("alu_result", alu_result, exp_alu);
      chk("zero", 32'(zero), 32'(exp_alu == 32'd0));
    end
    @(posedge clk);
    if (rst) begin
      md_left = 0; m_hi = '0; m_lo = '0;
    end else if (md_left > 0) begin
      md_left--;
      if (md_left == 0) begin m_hi = p_hi; m_lo = p_lo; end
    end else if (ALUop == 2'b10 && !ext_hold && (funct == 6'h19 || funct == 6'h1B)) begin
      if (funct == 6'h19) begin
        prod = 64'(RD1) * 64'(RD2);
        p_hi = prod[63:32]; p_lo = prod[31:0];
      end else if (RD2 == 0) begin
        p_lo = 32'hFFFF_FFFF; p_hi = RD1;
      end else begin
        p_lo = RD1 / RD2; p_hi = RD1 % RD2;
      end
      md_left = XLEN;
    end
    #1;
  endtask

  // Hold the current instruction until md_stall clears (bounded); returns stall cycles seen.
  task automatic run_stalled(output int n);
    n = 0;
    while (md_stall && n < 40) begin
      n++;
      cycle();
    end
  endtask

  logic [5:0] fn_tab [14] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h2A,
                              6'h00, 6'h02, 6'h10, 6'h12, 6'h19, 6'h1B, 6'h3F};

  initial begin
    int nst;
    nop();
    rst = 1;
    cycle();
    cycle();
    rst = 0;
    chk("rst_busy", 32'(md_busy), 32'd0);
    rtype(6'h12, 0, 0);
    #1 chk("rst_lo", alu_result, 32'd0);
    cycle();

    // Directed ALU cases.
    rtype(6'h2A, 32'hFFFF_FFFF, 32'd1);
    #1 chk("slt_neg", alu_result, 32'd1);
    cycle();
    rtype(6'h22, 32'd5, 32'd5);
    #1 chk("sub_zero", 32'(zero), 32'd1);
    cycle();
    nop(); ALUSrc = 1; RD1 = 32'h100; extend_immed = 32'hFFFF_FFFC; R31toReg = 1; RegDst = 1; rd = 5'd7;
    #1 chk("addi_neg", alu_result, 32'h0000_00FC);
    chk("jal_reg", 32'(wr_reg), 32'd31);
    cycle();
    nop(); ALUop = 2'b11; ALUSrc = 1; RD1 = 32'hF0F0_0000; extend_immed = 32'h0000_1234; rt = 5'd9;
    cycle();

    // multu max*max, then mfhi stalls for the full iteration count.
    nop(); rtype(6'h19, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    cycle();
    rtype(6'h10, 0, 0); RegWrite = 1; RegDst = 1; rd = 5'd3;
    run_stalled(nst);
    chk("mul_stall_len", 32'(nst), 32'd32);
    chk("mfhi_mul", alu_result, 32'hFFFF_FFFE);
    cycle();
    rtype(6'h12, 0, 0);
    #1 chk("mflo_mul", alu_result, 32'd1);
    cycle();

    // divu by zero and a regular divide.
    nop(); rtype(6'h1B, 32'd7, 32'd0);
    cycle();
    rtype(6'h12, 0, 0);
    run_stalled(nst);
    chk("div0_lo", alu_result, 32'hFFFF_FFFF);
    cycle();
    rtype(6'h10, 0, 0);
    #1 chk("div0_hi", alu_result, 32'd7);
    cycle();
    rtype(6'h1B, 32'h100, 32'd7);
    cycle();
    rtype(6'h12, 0, 0);
    run_stalled(nst);
    chk("div_stall_len", 32'(nst), 32'd32);
    chk("div_lo", alu_result, 32'h24);
    cycle();
    rtype(6'h10, 0, 0);
    #1 chk("div_hi", alu_result, 32'd4);
    cycle();

    // multu followed immediately by divu with all controls asserted: bubbles until issue.
    nop(); rtype(6'h19, 32'd1000, 32'd3000);
    cycle();
    rtype(6'h1B, 32'd1000, 32'd3); RegWrite = 1; MemRead = 1; MemWrite = 1; MemtoReg = 1;
    run_stalled(nst);
    chk("b2b_stall_len", 32'(nst), 32'd32);
    chk("b2b_issue_rw", 32'(ex_RegWrite), 32'd1);
    cycle();
    chk("b2b_busy", 32'(md_busy), 32'd1);
    nop(); rtype(6'h12, 0, 0);
    run_stalled(nst);
    chk("b2b_lo", alu_result, 32'd333);
    cycle();

    // Reset in the middle of a divide aborts it.
    nop(); rtype(6'h1B, 32'h100, 32'd7);
    cycle();
    nop(); rtype(6'h20, 32'd2, 32'd3);
    repeat (9) cycle();
    rst = 1;
    cycle();
    rst = 0;
    chk("rst_mid_busy", 32'(md_busy), 32'd0);
    rtype(6'h12, 0, 0);
    #1 chk("rst_mid_stall", 32'(md_stall), 32'd0);
    chk("rst_mid_lo", alu_result, 32'd0);
    cycle();

    // Randomized instruction stream.
    for (int i = 0; i < 400; i++) begin
      rst          = ($urandom_range(0, 149) == 0);
      ext_hold     = ($urandom_range(0, 3) == 0);
      RegDst       = 1'($urandom);
      ALUSrc       = 1'($urandom);
      RegWrite     = 1'($urandom);
      MemRead      = 1'($urandom);
      MemWrite     = 1'($urandom);
      MemtoReg     = 1'($urandom);
      R31toReg     = ($urandom_range(0, 7) == 0);
      ALUop        = ($urandom_range(0, 1) == 0) ? 2'b10 : 2'($urandom);
      funct        = fn_tab[$urandom_range(0, 13)];
      RD1          = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
      RD2          = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
      extend_immed = $urandom;
      rt           = 5'($urandom);
      rd           = 5'($urandom);
      shamt        = 5'($urandom);
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
